// File: rtl/rr_mux_reg_pkg.sv
// Shared helpers for the round-robin arbitrating mux.
package mux_pkg;

  // Channel-index width; never narrower than one bit so N=1..2 still gets a usable index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// Input-channel and output-word handshake bundle for rr_mux_reg.
interface rr_mux_reg_if
  import mux_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 64
);

  localparam int unsigned SEL_W = clog2_min1(N);

  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_ready;

  // Master drives the channel requests and consumes the output word.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  // Slave is the arbitrating mux itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

endinterface

// File: rtl/rr_mux_reg_pick.sv
// Combinational round-robin / fixed-priority pick of one requester.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  input  logic             fixed,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W-1:0] eff_start;
  logic             hit_hi;
  logic [SEL_W-1:0] idx_hi;
  logic [SEL_W-1:0] idx_lo;

  // Lowest requester at or above the start index wins; otherwise wrap to the lowest overall.
  always_comb begin
    eff_start = fixed ? '0 : start;
    hit_hi    = 1'b0;
    idx_hi    = '0;
    idx_lo    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = SEL_W'(i);
        if (SEL_W'(i) >= eff_start) begin
          hit_hi = 1'b1;
          idx_hi = SEL_W'(i);
        end
      end
    end
    gnt_vld = |req;
    gnt_idx = hit_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel arbitrating mux with a registered output word and its source index.
module rr_mux_reg
  import mux_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          prio_mode,
  rr_mux_reg_if.slave   bus
);

  localparam int unsigned SEL_W = clog2_min1(N);

  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             load_en;
  logic             xfer;
  logic [W-1:0]     sel_data;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req     (bus.in_valid),
    .start   (ptr_q),
    .fixed   (prio_mode),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Accept strobe; gated by reset so no channel sees a ready while the block is held.
  always_comb begin
    load_en      = reset_n && (!out_valid_q || bus.out_ready);
    xfer         = gnt_vld && load_en;
    bus.in_ready = xfer ? (N'(1) << gnt_idx) : '0;
  end

  // W-bit N:1 select of the granted channel's word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) sel_data = bus.in_data[i*W +: W];
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_chan_d  = gnt_idx;
      if (!prio_mode) begin
        ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (load_en) begin
      // Draining (or already empty) with nothing to load; data/chan keep stale values.
      out_valid_d = 1'b0;
    end
  end

  // State registers; asynchronous reset discards any held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed-vector bench for rr_mux_reg (N=8/W=64 main instance, N=5/W=8 wrap instance).
module tb_rr_mux_reg;

  logic clk;
  logic reset_n;
  logic prio_mode;

  int vec;
  int errs;

  rr_mux_reg_if #(.N(8), .W(64)) bus8 ();
  rr_mux_reg_if #(.N(5), .W(8))  bus5 ();

  rr_mux_reg #(.N(8), .W(64)) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .prio_mode (prio_mode),
    .bus       (bus8)
  );

  rr_mux_reg #(.N(5), .W(8)) dut5 (
    .clk       (clk),
    .reset_n   (reset_n),
    .prio_mode (prio_mode),
    .bus       (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic load_data();
    for (int i = 0; i < 8; i++) bus8.in_data[i*64 +: 64] = dat(i);
    for (int i = 0; i < 5; i++) bus5.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    prio_mode      = 1'b0;
    bus8.in_valid  = '0;
    bus8.out_ready = 1'b0;
    bus5.in_valid  = '0;
    bus5.out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    prio_mode      = 1'b0;
    bus8.in_valid  = 8'hFF;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus8.out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_out_valid got %b want 0", bus8.out_valid);
    end
    vec++;
    if (bus8.in_ready !== 8'h00) begin
      errs++; $display("FAIL reset_in_ready got %h want 00", bus8.in_ready);
    end
    vec++;
    if (bus8.out_data !== 64'h0 || bus8.out_chan !== 3'd0) begin
      errs++; $display("FAIL reset_data_chan got %h/%0d want 0/0", bus8.out_data, bus8.out_chan);
    end
    reset_n = 1'b1;
    #1;
    vec++;
    if (bus8.in_ready !== 8'h01) begin
      errs++; $display("FAIL release_in_ready got %h want 01", bus8.in_ready);
    end
    @(negedge clk);
    vec++;
    if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd0 || bus8.out_data !== dat(0)) begin
      errs++;
      $display("FAIL release_first_word got v=%b ch=%0d d=%h want v=1 ch=0 d=%h",
               bus8.out_valid, bus8.out_chan, bus8.out_data, dat(0));
    end
    bus8.in_valid = '0;
  endtask

  task automatic test_rr_fairness();
    logic [7:0] exp_rdy;
    do_reset();
    bus8.in_valid  = 8'hFF;
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_rdy = 8'h01 << ((k + 1) % 8);
      vec++;
      if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'(k % 8) ||
          bus8.out_data !== dat(k % 8)) begin
        errs++;
        $display("FAIL rr_word[%0d] got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", k,
                 bus8.out_valid, bus8.out_chan, bus8.out_data, k % 8, dat(k % 8));
      end
      vec++;
      if (bus8.in_ready !== exp_rdy) begin
        errs++; $display("FAIL rr_in_ready[%0d] got %h want %h", k, bus8.in_ready, exp_rdy);
      end
    end
    bus8.in_valid = '0;
  endtask

  task automatic test_wrap_skip();
    int exp8 [3] = '{0, 2, 0};
    int exp5 [3] = '{4, 0, 4};
    // N=8: a single ch5 word leaves ptr at 6.
    do_reset();
    bus8.in_valid  = 8'h20;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus8.out_chan !== 3'd5) begin
      errs++; $display("FAIL wrap8_seed got %0d want 5", bus8.out_chan);
    end
    bus8.in_valid = 8'b0000_0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'(exp8[k])) begin
        errs++;
        $display("FAIL wrap8[%0d] got v=%b ch=%0d want v=1 ch=%0d", k, bus8.out_valid,
                 bus8.out_chan, exp8[k]);
      end
    end
    bus8.in_valid = '0;
    // N=5: a single ch3 word leaves ptr at 4; ch4 then wraps the pointer to 0.
    do_reset();
    bus5.in_valid  = 5'b01000;
    bus5.out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus5.out_chan !== 3'd3 || bus5.out_data !== 8'hA3) begin
      errs++;
      $display("FAIL wrap5_seed got ch=%0d d=%h want ch=3 d=a3", bus5.out_chan, bus5.out_data);
    end
    bus5.in_valid = 5'b10001;
    #1;
    vec++;
    if (bus5.in_ready !== 5'b10000) begin
      errs++; $display("FAIL wrap5_in_ready got %b want 10000", bus5.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (bus5.out_valid !== 1'b1 || bus5.out_chan !== 3'(exp5[k])) begin
        errs++;
        $display("FAIL wrap5[%0d] got v=%b ch=%0d want v=1 ch=%0d", k, bus5.out_valid,
                 bus5.out_chan, exp5[k]);
      end
    end
    bus5.in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus8.in_data[3*64 +: 64] = 64'h0000_0000_DEAD_BEEF;
    bus8.in_valid  = 8'h08;
    bus8.out_ready = 1'b0;
    #1;
    vec++;
    if (bus8.in_ready !== 8'h08) begin
      errs++; $display("FAIL bp_accept got %h want 08", bus8.in_ready);
    end
    @(negedge clk);
    // ch3 accepted; a new request from ch0 must wait out the stall.
    bus8.in_valid = 8'h01;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec++;
      if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd3 ||
          bus8.out_data !== 64'h0000_0000_DEAD_BEEF || bus8.in_ready !== 8'h00) begin
        errs++;
        $display("FAIL bp_stall[%0d] got v=%b ch=%0d d=%h rdy=%h want v=1 ch=3 d=deadbeef rdy=00",
                 k, bus8.out_valid, bus8.out_chan, bus8.out_data, bus8.in_ready);
      end
      @(negedge clk);
    end
    bus8.out_ready = 1'b1;
    #1;
    vec++;
    if (bus8.in_ready !== 8'h01) begin
      errs++; $display("FAIL bp_drain_load got %h want 01", bus8.in_ready);
    end
    @(negedge clk);
    bus8.in_valid = '0;
    vec++;
    if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd0 || bus8.out_data !== dat(0)) begin
      errs++;
      $display("FAIL bp_next_word got v=%b ch=%0d d=%h want v=1 ch=0 d=%h", bus8.out_valid,
               bus8.out_chan, bus8.out_data, dat(0));
    end
    @(negedge clk);
    vec++;
    if (bus8.out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_no_dup got v=%b want 0", bus8.out_valid);
    end
    bus8.in_data[3*64 +: 64] = dat(3);
  endtask

  task automatic test_fixed_mode();
    do_reset();
    prio_mode      = 1'b1;
    bus8.in_valid  = 8'b1010_0000;
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd5) begin
        errs++;
        $display("FAIL fixed_ch5[%0d] got v=%b ch=%0d want v=1 ch=5", k, bus8.out_valid,
                 bus8.out_chan);
      end
    end
    bus8.in_valid = 8'b1000_0000;
    @(negedge clk);
    vec++;
    if (bus8.out_chan !== 3'd7 || bus8.out_data !== dat(7)) begin
      errs++;
      $display("FAIL fixed_ch7 got ch=%0d d=%h want ch=7 d=%h", bus8.out_chan, bus8.out_data,
               dat(7));
    end
    // Pointer untouched by fixed-mode grants, so round-robin resumes at channel 0.
    prio_mode     = 1'b0;
    bus8.in_valid = 8'hFF;
    @(negedge clk);
    vec++;
    if (bus8.out_chan !== 3'd0) begin
      errs++; $display("FAIL fixed_ptr_kept got ch=%0d want 0", bus8.out_chan);
    end
    bus8.in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus8.in_valid  = 8'h04;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid  = 8'h40;
    bus8.out_ready = 1'b0;
    @(negedge clk);
    vec++;
    if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd2) begin
      errs++;
      $display("FAIL ar_stall got v=%b ch=%0d want v=1 ch=2", bus8.out_valid, bus8.out_chan);
    end
    bus8.in_valid = '0;
    #2 reset_n = 1'b0;
    #1;
    vec++;
    if (bus8.out_valid !== 1'b0) begin
      errs++; $display("FAIL ar_immediate got v=%b want 0", bus8.out_valid);
    end
    #1 reset_n = 1'b1;
    bus8.in_valid  = 8'hFF;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd0) begin
      errs++;
      $display("FAIL ar_fresh_ptr got v=%b ch=%0d want v=1 ch=0", bus8.out_valid,
               bus8.out_chan);
    end
    bus8.in_valid = '0;
  endtask

  initial begin
    vec            = 0;
    errs           = 0;
    bus8.in_valid  = '0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;
    bus5.in_valid  = '0;
    bus5.in_data   = '0;
    bus5.out_ready = 1'b0;
    load_data();
    test_reset();
    test_rr_fairness();
    test_wrap_skip();
    test_backpressure();
    test_fixed_mode();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
